// File: rtl/aes_sub_bytes_pipe.sv
// Pipelined AES byte substitution: forward or inverse S-box on LANES bytes per transaction.
// Substitution is combinational ahead of stage 1. The remaining stages are plain register
// slices with a valid/ready handshake. Capacity is exactly STAGES transactions.
module aes_sub_bytes_pipe #(
  parameter int unsigned LANES  = 16,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_inv,
  input  logic [8*LANES-1:0] in_data,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_inv
);

  localparam int unsigned DW = 8 * LANES;

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1, reducing as the multiplicand shifts.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254. Zero maps to zero, as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);  // a^(2^i)
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  // Forward affine map: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  function automatic logic [7:0] aff_fwd(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
           ^ 8'h63;
  endfunction

  // Inverse affine map: rotl1 ^ rotl3 ^ rotl6 ^ 0x05.
  function automatic logic [7:0] aff_inv(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
  endfunction

  // One inverter per lane serves both directions; only the affine step is mode dependent.
  function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
    logic [7:0] pre;
    logic [7:0] y;
    pre = inv ? aff_inv(b) : b;
    y   = gf_inv(pre);
    return inv ? y : aff_fwd(y);
  endfunction

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] inv_q;
  logic [DW-1:0]     data_q [STAGES];
  logic [TAG_W-1:0]  tag_q  [STAGES];
  logic [STAGES-1:0] adv;
  logic [DW-1:0]     sub_data;

  // Substitute every lane of the incoming transaction with its own mode bit.
  always_comb begin
    sub_data = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      sub_data[8*l +: 8] = sub_byte(in_data[8*l +: 8], in_inv);
    end
  end

  // A stage is blocked only if it and every stage after it is full while the output stalls.
  always_comb begin
    logic blocked;
    blocked = ~out_ready;
    adv     = '0;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      blocked = blocked & valid_q[k];
      adv[k]  = ~blocked;
    end
  end

  assign in_ready = ~flush & adv[0];

  // Pipeline registers; payload only loads when a valid transaction moves in, so a bubble
  // or a flush leaves the previous output data and tag in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      inv_q   <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        data_q[k] <= '0;
        tag_q[k]  <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      if (adv[0]) begin
        valid_q[0] <= in_valid;
        if (in_valid) begin
          data_q[0] <= sub_data;
          tag_q[0]  <= in_tag;
          inv_q[0]  <= in_inv;
        end
      end
      for (int k = 1; k < int'(STAGES); k++) begin
        if (adv[k]) begin
          valid_q[k] <= valid_q[k-1];
          if (valid_q[k-1]) begin
            data_q[k] <= data_q[k-1];
            tag_q[k]  <= tag_q[k-1];
            inv_q[k]  <= inv_q[k-1];
          end
        end
      end
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];
  assign out_inv   = inv_q[STAGES-1];

endmodule

// File: tb/tb_aes_sub_bytes_pipe.sv
// Scoreboard bench for aes_sub_bytes_pipe: a main 16-lane/2-stage instance with directed and
// random traffic, plus 4-lane instances with 1 and 4 stages on shared random traffic.
module tb_aes_sub_bytes_pipe;

  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   tag;
    logic         inv;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  exp_t q_m[$];
  exp_t q_1[$];
  exp_t q_4[$];

  // Main instance.
  logic         m_flush, m_in_valid, m_in_ready, m_in_inv, m_out_valid, m_out_ready, m_out_inv;
  logic [127:0] m_in_data, m_out_data;
  logic [3:0]   m_in_tag, m_out_tag;

  // Small instances share their input drive.
  logic         s_flush, s_in_valid, s_in_inv, s_out_ready;
  logic [31:0]  s_in_data;
  logic [3:0]   s_in_tag;
  logic         s1_in_ready, s1_out_valid, s1_out_inv, s4_in_ready, s4_out_valid, s4_out_inv;
  logic [31:0]  s1_out_data, s4_out_data;
  logic [3:0]   s1_out_tag, s4_out_tag;

  aes_sub_bytes_pipe #(.LANES(16), .STAGES(2), .TAG_W(4)) u_main (
    .clk(clk), .rst_n(rst_n), .flush(m_flush), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .in_inv(m_in_inv), .in_data(m_in_data), .in_tag(m_in_tag), .out_valid(m_out_valid),
    .out_ready(m_out_ready), .out_data(m_out_data), .out_tag(m_out_tag), .out_inv(m_out_inv)
  );

  aes_sub_bytes_pipe #(.LANES(4), .STAGES(1), .TAG_W(4)) u_s1 (
    .clk(clk), .rst_n(rst_n), .flush(s_flush), .in_valid(s_in_valid), .in_ready(s1_in_ready),
    .in_inv(s_in_inv), .in_data(s_in_data), .in_tag(s_in_tag), .out_valid(s1_out_valid),
    .out_ready(s_out_ready), .out_data(s1_out_data), .out_tag(s1_out_tag), .out_inv(s1_out_inv)
  );

  aes_sub_bytes_pipe #(.LANES(4), .STAGES(4), .TAG_W(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .flush(s_flush), .in_valid(s_in_valid), .in_ready(s4_in_ready),
    .in_inv(s_in_inv), .in_data(s_in_data), .in_tag(s_in_tag), .out_valid(s4_out_valid),
    .out_ready(s_out_ready), .out_data(s4_out_data), .out_tag(s4_out_tag), .out_inv(s4_out_inv)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference multiply: full polynomial product, then long division by 0x11b.
  function automatic logic [7:0] mdl_mul(input int a, input int b);
    int p;
    p = 0;
    for (int i = 0; i < 8; i++) if (((b >> i) & 1) != 0) p = p ^ (a << i);
    for (int i = 14; i >= 8; i--) if (((p >> i) & 1) != 0) p = p ^ (32'h11b << (i - 8));
    return p[7:0];
  endfunction

  // Forward table from brute-force inverse search plus the bitwise affine rule;
  // inverse table is the forward table read backwards.
  task automatic build_model();
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      int         iv;
      logic [7:0] b;
      logic [7:0] s;
      iv = 0;
      for (int y = 1; y < 256; y++) if (x != 0 && mdl_mul(x, y) == 8'h01) iv = y;
      b = iv[7:0];
      for (int i = 0; i < 8; i++) begin
        s[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8] ^ c[i];
      end
      fwd_tab[x] = s;
      inv_tab[s] = x[7:0];
    end
  endtask

  function automatic logic [127:0] model_sub(input logic [127:0] d, input logic inv,
                                             input int lanes);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < lanes; i++) begin
      r[8*i +: 8] = inv ? inv_tab[d[8*i +: 8]] : fwd_tab[d[8*i +: 8]];
    end
    return r;
  endfunction

  // Main monitor: pops on delivery, checks hold-stability under stall, tracks valid runs.
  logic         m_prev_stall = 1'b0;
  logic [127:0] m_prev_data;
  logic [3:0]   m_prev_tag;
  logic         m_prev_inv;
  int           m_run = 0;
  int           m_run_max = 0;

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n && m_out_valid && m_out_ready && !m_flush) begin
      if (q_m.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL main_unexpected actual=output required=none tag=%h", m_out_tag);
      end else begin
        e = q_m.pop_front();
        check("main_data", m_out_data, e.data);
        check("main_tag", 128'(m_out_tag), 128'(e.tag));
        check("main_inv", 128'(m_out_inv), 128'(e.inv));
      end
    end
    if (rst_n && m_prev_stall && m_out_valid) begin
      check("main_hold_data", m_out_data, m_prev_data);
      check("main_hold_tag", 128'(m_out_tag), 128'(m_prev_tag));
      check("main_hold_inv", 128'(m_out_inv), 128'(m_prev_inv));
    end
    m_prev_stall = rst_n && m_out_valid && !m_out_ready && !m_flush;
    m_prev_data  = m_out_data;
    m_prev_tag   = m_out_tag;
    m_prev_inv   = m_out_inv;
    if (rst_n && m_out_valid) m_run++;
    else m_run = 0;
    if (m_run > m_run_max) m_run_max = m_run;
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n && s1_out_valid && s_out_ready) begin
      if (q_1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL s1_unexpected actual=output required=none tag=%h", s1_out_tag);
      end else begin
        e = q_1.pop_front();
        check("s1_data", 128'(s1_out_data), e.data);
        check("s1_tag_inv", 128'({s1_out_tag, s1_out_inv}), 128'({e.tag, e.inv}));
      end
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n && s4_out_valid && s_out_ready) begin
      if (q_4.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL s4_unexpected actual=output required=none tag=%h", s4_out_tag);
      end else begin
        e = q_4.pop_front();
        check("s4_data", 128'(s4_out_data), e.data);
        check("s4_tag_inv", 128'({s4_out_tag, s4_out_inv}), 128'({e.tag, e.inv}));
      end
    end
  end

  // One cycle of main-instance drive; the expected result is queued when the input is taken.
  task automatic m_step(input logic v, input logic inv, input logic [127:0] d,
                        input logic [3:0] tag, input logic ordy, input logic fl,
                        input logic [127:0] expd, output logic acc);
    exp_t e;
    @(posedge clk);
    #1;
    m_in_valid  = v;
    m_in_inv    = inv;
    m_in_data   = d;
    m_in_tag    = tag;
    m_out_ready = ordy;
    m_flush     = fl;
    @(negedge clk);
    acc = v && m_in_ready;
    if (fl) begin
      q_m.delete();
    end else if (acc) begin
      e.data = expd;
      e.tag  = tag;
      e.inv  = inv;
      q_m.push_back(e);
    end
  endtask

  task automatic m_idle();
    logic acc;
    m_step(1'b0, 1'b0, '0, 4'h0, 1'b1, 1'b0, '0, acc);
  endtask

  task automatic m_push(input logic inv, input logic [127:0] d, input logic [3:0] tag,
                        input logic [127:0] expd);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) m_step(1'b1, inv, d, tag, 1'b1, 1'b0, expd, acc);
    check("main_push_accepted", 128'(acc), 128'd1);
  endtask

  task automatic m_drain();
    for (int i = 0; i < 40 && q_m.size() != 0; i++) m_idle();
    check("main_drain_empty", 128'(q_m.size()), 128'd0);
  endtask

  // Random traffic on all three instances with random backpressure.
  task automatic rand_cycle();
    exp_t        e;
    logic [31:0] r;
    @(posedge clk);
    #1;
    r           = $urandom;
    m_in_valid  = (r[1:0] != 2'b00);
    m_in_inv    = r[2];
    m_in_tag    = r[7:4];
    m_out_ready = (r[9:8] != 2'b00);
    m_flush     = 1'b0;
    m_in_data   = {$urandom, $urandom, $urandom, $urandom};
    s_in_valid  = (r[17:16] != 2'b00);
    s_in_inv    = r[18];
    s_in_tag    = r[23:20];
    s_out_ready = (r[25:24] != 2'b00);
    s_in_data   = $urandom;
    @(negedge clk);
    if (m_in_valid && m_in_ready) begin
      e.data = model_sub(m_in_data, m_in_inv, 16);
      e.tag  = m_in_tag;
      e.inv  = m_in_inv;
      q_m.push_back(e);
    end
    e.data = model_sub({96'h0, s_in_data}, s_in_inv, 4);
    e.tag  = s_in_tag;
    e.inv  = s_in_inv;
    if (s_in_valid && s1_in_ready) q_1.push_back(e);
    if (s_in_valid && s4_in_ready) q_4.push_back(e);
  endtask

  task automatic check_reset_outputs();
    check("rst_main_valid", 128'(m_out_valid), 128'd0);
    check("rst_main_data", m_out_data, 128'd0);
    check("rst_main_tag_inv", 128'({m_out_tag, m_out_inv}), 128'd0);
    check("rst_s1_outs", 128'({s1_out_valid, s1_out_inv, s1_out_tag, s1_out_data}), 128'd0);
    check("rst_s4_outs", 128'({s4_out_valid, s4_out_inv, s4_out_tag, s4_out_data}), 128'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic         acc;
    logic [127:0] d;
    logic [127:0] xd;
    logic [127:0] bp_d [4];
    logic [3:0]   bp_inv;
    int           k;
    int           n_acc;

    m_flush = 0; m_in_valid = 0; m_in_inv = 0; m_in_data = '0; m_in_tag = '0; m_out_ready = 1;
    s_flush = 0; s_in_valid = 0; s_in_inv = 0; s_in_data = '0; s_in_tag = '0; s_out_ready = 1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    build_model();
    check("model_fwd_53", 128'(fwd_tab[8'h53]), 128'h ed);
    check("model_fwd_ff", 128'(fwd_tab[8'hff]), 128'h16);
    check("model_inv_63", 128'(inv_tab[8'h63]), 128'h00);
    check("model_inv_16", 128'(inv_tab[8'h16]), 128'hff);

    // Reset state, then release between edges.
    #20;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_in_ready", 128'({m_in_ready, s1_in_ready, s4_in_ready}), 128'b111);

    // Known vector and two-edge latency.
    d = 128'h0f0e0d0c0b0a09080706050403020100;
    m_step(1'b1, 1'b0, d, 4'h5, 1'b1, 1'b0, model_sub(d, 1'b0, 16), acc);
    check("vec_accept", 128'(acc), 128'd1);
    m_idle();
    check("vec_not_early", 128'(m_out_valid), 128'd0);
    m_idle();
    check("vec_valid", 128'(m_out_valid), 128'd1);
    check("vec_data", m_out_data, 128'h76abd7fe2b670130c56f6bf27b777c63);
    check("vec_tag_inv", 128'({m_out_tag, m_out_inv}), 128'({4'h5, 1'b0}));
    m_drain();

    // Exhaustive lane-rotated sweep: forward, inverse, then forward results fed back inverted.
    for (int t = 0; t < 256; t++) begin
      for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(t + i);
      m_push(1'b0, d, 4'(t), model_sub(d, 1'b0, 16));
    end
    for (int t = 0; t < 256; t++) begin
      for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(t + i);
      m_push(1'b1, d, 4'(t), model_sub(d, 1'b1, 16));
    end
    for (int t = 0; t < 256; t++) begin
      for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(t + i);
      m_push(1'b1, model_sub(d, 1'b0, 16), 4'(t), d);
    end
    m_drain();

    // Back-to-back stream of 20 with alternating mode.
    m_idle();
    m_run_max = 0;
    n_acc = 0;
    for (int i = 0; i < 20; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      m_step(1'b1, i[0], d, 4'(i), 1'b1, 1'b0, model_sub(d, i[0], 16), acc);
      if (acc) n_acc++;
    end
    check("b2b_accepted", 128'(n_acc), 128'd20);
    m_drain();
    check("b2b_valid_run", 128'(m_run_max), 128'd20);

    // Backpressure: only STAGES slots fill, ready returns as soon as the last stage moves.
    for (int i = 0; i < 4; i++) bp_d[i] = {$urandom, $urandom, $urandom, $urandom};
    bp_inv = 4'($urandom);
    k = 0;
    for (int c = 0; c < 6; c++) begin
      m_step(1'b1, bp_inv[k], bp_d[k], 4'(k + 8), 1'b0, 1'b0,
             model_sub(bp_d[k], bp_inv[k], 16), acc);
      if (acc) k++;
    end
    check("bp_accepted", 128'(k), 128'd2);
    check("bp_in_ready_low", 128'(m_in_ready), 128'd0);
    m_step(1'b1, bp_inv[k], bp_d[k], 4'(k + 8), 1'b1, 1'b0,
           model_sub(bp_d[k], bp_inv[k], 16), acc);
    check("bp_ready_return", 128'(acc), 128'd1);
    m_push(bp_inv[3], bp_d[3], 4'hb, model_sub(bp_d[3], bp_inv[3], 16));
    m_drain();

    // Flush with two in flight and a competing input.
    xd = {$urandom, $urandom, $urandom, $urandom};
    d  = {$urandom, $urandom, $urandom, $urandom};
    m_step(1'b1, 1'b0, xd, 4'h1, 1'b1, 1'b0, model_sub(xd, 1'b0, 16), acc);
    m_step(1'b1, 1'b1, d, 4'h2, 1'b1, 1'b0, model_sub(d, 1'b1, 16), acc);
    m_step(1'b1, 1'b0, d, 4'h3, 1'b1, 1'b1, model_sub(d, 1'b0, 16), acc);
    check("flush_no_accept", 128'(acc), 128'd0);
    m_idle();
    check("flush_valid_clear", 128'(m_out_valid), 128'd0);
    check("flush_data_hold", m_out_data, model_sub(xd, 1'b0, 16));
    check("flush_tag_hold", 128'(m_out_tag), 128'h1);
    d = {$urandom, $urandom, $urandom, $urandom};
    m_step(1'b1, 1'b1, d, 4'h4, 1'b1, 1'b0, model_sub(d, 1'b1, 16), acc);
    check("post_flush_accept", 128'(acc), 128'd1);
    m_idle();
    check("post_flush_not_early", 128'(m_out_valid), 128'd0);
    m_idle();
    check("post_flush_valid", 128'(m_out_valid), 128'd1);
    m_drain();

    // Random traffic on all instances, asynchronous reset mid-stream, more traffic, drain.
    for (int i = 0; i < 200; i++) rand_cycle();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    m_in_valid = 1'b0;
    s_in_valid = 1'b0;
    #1;
    check_reset_outputs();
    q_m.delete();
    q_1.delete();
    q_4.delete();
    @(posedge clk);
    #4;
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", 128'({m_in_ready, s1_in_ready, s4_in_ready}), 128'b111);
    for (int i = 0; i < 200; i++) rand_cycle();
    for (int i = 0; i < 60 && (q_m.size() + q_1.size() + q_4.size()) != 0; i++) begin
      @(posedge clk);
      #1;
      m_in_valid  = 1'b0;
      s_in_valid  = 1'b0;
      m_out_ready = 1'b1;
      s_out_ready = 1'b1;
      @(negedge clk);
    end
    check("final_q_main", 128'(q_m.size()), 128'd0);
    check("final_q_s1", 128'(q_1.size()), 128'd0);
    check("final_q_s4", 128'(q_4.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
